// File: rtl/pressure_pkg.sv
// pressure_pkg: shared types and constants for the airlock pressure pump.
//   state_e : pump FSM state (IDLE, PUMP, VENT)
//   LEVEL_W : width of the chamber level register
package pressure_pkg;

  localparam int LEVEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUMP = 2'd1,
    VENT = 2'd2
  } state_e;

endpackage

// File: rtl/pressure_pump_step_timer.sv
// step_timer: free-running modulo-CYCLES counter with a terminal-count pulse.
//   clk_i / rst_i : clock, async active-high reset
//   clr_i         : synchronous clear to 0 (wins over en_i)
//   en_i          : count enable
//   tc_o          : high while enabled on the last count (CYCLES-1); the
//                   counter wraps to 0 on that same edge
module step_timer #(
  parameter int CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt_q;

  assign tc_o = en_i && (cnt_q == LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= tc_o ? '0 : cnt_q + W'(1);
  end

endmodule

// File: rtl/pressure_pump.sv
// pressure_pump: airlock chamber pressure controller.
//   Clock, Reset            : clock, async active-high reset
//   Depressurize/Pressurize : pump down to 0 / vent up to LEVEL_MAX
//   InnerClosed/OuterClosed : door status; both must be closed to operate
//   ClearFault              : synchronous clear of the sticky Fault flag
//   Pressurized/Evacuated   : Level at LEVEL_MAX / at 0
//   PumpOn/VentOn           : FSM is in PUMP / VENT
//   Level                   : chamber level register
//   Fault                   : sticky error (door opened mid-operation or
//                             conflicting commands)
// Optional: define LEAK_SIM_EN to let the chamber creep up one level every
// LEAK_CYCLES clocks while idle below LEVEL_MAX.
module pressure_pump
  import pressure_pkg::*;
#(
  parameter int LEVEL_MAX   = 8,
  parameter int STEP_CYCLES = 2,
  parameter int LEAK_CYCLES = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Depressurize,
  input  logic               Pressurize,
  input  logic               InnerClosed,
  input  logic               OuterClosed,
  input  logic               ClearFault,
  output logic               Pressurized,
  output logic               Evacuated,
  output logic               PumpOn,
  output logic               VentOn,
  output logic [LEVEL_W-1:0] Level,
  output logic               Fault
);

  localparam logic [LEVEL_W-1:0] LMAX = LEVEL_W'(LEVEL_MAX);

  // Reject out-of-range configurations at elaboration.
  if (LEVEL_MAX < 1 || LEVEL_MAX > 15 || STEP_CYCLES < 1 || STEP_CYCLES > 255 ||
      LEAK_CYCLES < 1) begin : g_bad_cfg
    $error("pressure_pump: parameter out of range");
  end

  state_e             state_q;
  logic [LEVEL_W-1:0] level_q;
  logic               fault_q;

  logic both_cmd, doors_ok, step_tc, leak_tc;

  assign both_cmd = Depressurize && Pressurize;
  assign doors_ok = InnerClosed && OuterClosed;

  // Counter is held clear in IDLE so every PUMP/VENT entry starts at 0.
  step_timer #(.CYCLES(STEP_CYCLES)) u_step (
    .clk_i (Clock),
    .rst_i (Reset),
    .clr_i (state_q == IDLE),
    .en_i  (state_q != IDLE),
    .tc_o  (step_tc)
  );

`ifdef LEAK_SIM_EN
  step_timer #(.CYCLES(LEAK_CYCLES)) u_leak (
    .clk_i (Clock),
    .rst_i (Reset),
    .clr_i ((state_q != IDLE) || (level_q == LMAX)),
    .en_i  ((state_q == IDLE) && (level_q != LMAX)),
    .tc_o  (leak_tc)
  );
`else
  assign leak_tc = 1'b0;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      level_q <= LMAX;
      fault_q <= 1'b0;
    end else begin
      // A fault condition on the same edge beats ClearFault.
      if (both_cmd || (state_q != IDLE && !doors_ok)) fault_q <= 1'b1;
      else if (ClearFault)                           fault_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (Depressurize && !Pressurize && doors_ok && level_q != '0 && !fault_q)
            state_q <= PUMP;
          else if (Pressurize && !Depressurize && doors_ok && level_q != LMAX && !fault_q)
            state_q <= VENT;
          else if (leak_tc)
            level_q <= level_q + LEVEL_W'(1);
        end
        PUMP: begin
          // Abort (command drop, conflict or open door) holds the level.
          if (!Depressurize || Pressurize || !doors_ok) begin
            state_q <= IDLE;
          end else if (step_tc) begin
            level_q <= level_q - LEVEL_W'(1);
            if (level_q == LEVEL_W'(1)) state_q <= IDLE;
          end
        end
        VENT: begin
          if (!Pressurize || Depressurize || !doors_ok) begin
            state_q <= IDLE;
          end else if (step_tc) begin
            level_q <= level_q + LEVEL_W'(1);
            if (level_q == LMAX - LEVEL_W'(1)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Pressurized = (level_q == LMAX);
  assign Evacuated   = (level_q == '0);
  assign PumpOn      = (state_q == PUMP);
  assign VentOn      = (state_q == VENT);
  assign Level       = level_q;
  assign Fault       = fault_q;

endmodule

// File: tb/tb_pressure_pump.sv
// tb_pressure_pump: scoreboard bench for pressure_pump (default parameters).
// A reference model predicts the post-edge state for each driven cycle and
// queues it; the entry is popped and compared after the edge.
module tb_pressure_pump;

  localparam int LMAX = 8;
  localparam int STEP = 2;
  localparam int LEAK = 16;

  logic       Clock, Reset;
  logic       Depressurize, Pressurize, InnerClosed, OuterClosed, ClearFault;
  logic       Pressurized, Evacuated, PumpOn, VentOn, Fault;
  logic [3:0] Level;

  pressure_pump #(.LEVEL_MAX(LMAX), .STEP_CYCLES(STEP), .LEAK_CYCLES(LEAK)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Depressurize (Depressurize),
    .Pressurize   (Pressurize),
    .InnerClosed  (InnerClosed),
    .OuterClosed  (OuterClosed),
    .ClearFault   (ClearFault),
    .Pressurized  (Pressurized),
    .Evacuated    (Evacuated),
    .PumpOn       (PumpOn),
    .VentOn       (VentOn),
    .Level        (Level),
    .Fault        (Fault)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    int level;
    int st;     // 0 idle, 1 pump, 2 vent
    int fault;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // reference model state
  int m_st, m_level, m_fault, m_cnt, m_lcnt;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_st = 0; m_level = LMAX; m_fault = 0; m_cnt = 0; m_lcnt = 0;
  endtask

  // Predict the result of the next rising edge from current inputs.
  task automatic model_push();
    int ns, nl, nf, nc, nlc;
    bit both, doors;
    exp_t e;
    ns = m_st; nl = m_level; nf = m_fault; nc = m_cnt; nlc = m_lcnt;
    both  = Depressurize && Pressurize;
    doors = InnerClosed && OuterClosed;
    if (both || (m_st != 0 && !doors)) nf = 1;
    else if (ClearFault)               nf = 0;
    case (m_st)
      0: begin
        nc = 0;
        if (!both && Depressurize && doors && m_level > 0 && m_fault == 0) ns = 1;
        else if (!both && Pressurize && doors && m_level < LMAX && m_fault == 0) ns = 2;
`ifdef LEAK_SIM_EN
        if (m_level < LMAX) begin
          if (m_lcnt == LEAK - 1) begin
            nlc = 0;
            if (ns == 0) nl = m_level + 1;
          end else nlc = m_lcnt + 1;
        end else nlc = 0;
`endif
      end
      1: begin
        nlc = 0;
        if (!Depressurize || Pressurize || !doors) ns = 0;
        else if (m_cnt == STEP - 1) begin
          nc = 0; nl = m_level - 1;
          if (nl == 0) ns = 0;
        end else nc = m_cnt + 1;
      end
      default: begin
        nlc = 0;
        if (!Pressurize || Depressurize || !doors) ns = 0;
        else if (m_cnt == STEP - 1) begin
          nc = 0; nl = m_level + 1;
          if (nl == LMAX) ns = 0;
        end else nc = m_cnt + 1;
      end
    endcase
    m_st = ns; m_level = nl; m_fault = nf; m_cnt = nc; m_lcnt = nlc;
    e.level = nl; e.st = ns; e.fault = nf;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    model_push();
    @(posedge Clock);
    #1;
    e = exp_q.pop_front();
    chk("level",       int'(Level),       e.level);
    chk("fault",       int'(Fault),       e.fault);
    chk("pump_on",     int'(PumpOn),      (e.st == 1) ? 1 : 0);
    chk("vent_on",     int'(VentOn),      (e.st == 2) ? 1 : 0);
    chk("pressurized", int'(Pressurized), (e.level == LMAX) ? 1 : 0);
    chk("evacuated",   int'(Evacuated),   (e.level == 0) ? 1 : 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_level"}, int'(Level), LMAX);
    chk({tag, "_press"}, int'(Pressurized), 1);
    chk({tag, "_evac"},  int'(Evacuated), 0);
    chk({tag, "_pump"},  int'(PumpOn), 0);
    chk({tag, "_vent"},  int'(VentOn), 0);
    chk({tag, "_fault"}, int'(Fault), 0);
  endtask

  initial begin
    int n;
    Reset = 1'b1; Depressurize = 0; Pressurize = 0;
    InnerClosed = 1; OuterClosed = 1; ClearFault = 0;
    model_reset();
    #12;
    chk_reset_state("rst");
    Reset = 1'b0;

    // Full pump-down from reset: edge 1 enters PUMP, edge 17 reaches 0.
    Depressurize = 1;
    for (int i = 1; i <= 17; i++) begin
      cyc();
      if (i == 1)  chk("pd_pumpon_e1", int'(PumpOn), 1);
      if (i == 3)  chk("pd_level_e3", int'(Level), 7);
      if (i == 17) begin
        chk("pd_level_e17", int'(Level), 0);
        chk("pd_evac_e17",  int'(Evacuated), 1);
        chk("pd_pump_e17",  int'(PumpOn), 0);
      end
    end

    // Full vent from 0.
    Depressurize = 0; Pressurize = 1;
    for (int i = 1; i <= 17; i++) begin
      cyc();
      if (i == 1)  chk("vt_venton_e1", int'(VentOn), 1);
      if (i == 17) begin
        chk("vt_level_e17", int'(Level), 8);
        chk("vt_press_e17", int'(Pressurized), 1);
        chk("vt_vent_e17",  int'(VentOn), 0);
      end
    end

    // Door opens while pumping at level 5.
    Pressurize = 0; Depressurize = 1;
    n = 0;
    while (m_level != 5 && n < 30) begin cyc(); n++; end
    if (n >= 30) chk("bound_lvl5", 0, 1);
    OuterClosed = 0;
    cyc();
    chk("door_level", int'(Level), 5);
    chk("door_fault", int'(Fault), 1);
    chk("door_pump",  int'(PumpOn), 0);
    OuterClosed = 1;
    repeat (4) cyc();
    chk("blocked_pump", int'(PumpOn), 0);
    ClearFault = 1;
    cyc();
    ClearFault = 0;
    chk("clr_fault", int'(Fault), 0);
    cyc();
    chk("resume_pump", int'(PumpOn), 1);

    // Reset in the middle of pumping at level 3.
    n = 0;
    while (m_level != 3 && n < 30) begin cyc(); n++; end
    if (n >= 30) chk("bound_lvl3", 0, 1);
    chk("pre_rst_pump", int'(PumpOn), 1);
    #2 Reset = 1'b1;
    #1 chk_reset_state("midrst");
    model_reset();
    #2 Reset = 1'b0;
    Depressurize = 0;

    // Conflicting commands from IDLE; set beats ClearFault.
    Depressurize = 1; Pressurize = 1;
    cyc();
    chk("both_fault", int'(Fault), 1);
    chk("both_level", int'(Level), 8);
    ClearFault = 1;
    cyc();
    chk("both_setwins", int'(Fault), 1);
    Depressurize = 0; Pressurize = 0;
    cyc();
    chk("both_cleared", int'(Fault), 0);
    ClearFault = 0;

    // Command dropped mid-pump: IDLE, level held, no fault.
    Depressurize = 1;
    repeat (5) cyc();
    Depressurize = 0;
    cyc();
    chk("drop_pump", int'(PumpOn), 0);
    chk("drop_fault", int'(Fault), 0);

    // Random mix.
    for (int i = 0; i < 120; i++) begin
      Depressurize = ($urandom_range(0, 9) < 5);
      Pressurize   = ($urandom_range(0, 9) < 4);
      InnerClosed  = ($urandom_range(0, 19) != 0);
      OuterClosed  = ($urandom_range(0, 19) != 0);
      ClearFault   = ($urandom_range(0, 4) == 0);
      cyc();
    end

    // Idle at level 0: leak behaviour.
    Reset = 1'b1; #1; model_reset(); #1 Reset = 1'b0;
    Depressurize = 1; Pressurize = 0; InnerClosed = 1; OuterClosed = 1; ClearFault = 0;
    repeat (17) cyc();
    chk("leak_start0", int'(Level), 0);
    Depressurize = 0;
`ifdef LEAK_SIM_EN
    repeat (15) cyc();
    chk("leak_pre", int'(Level), 0);
    cyc();
    chk("leak_after16", int'(Level), 1);
`else
    repeat (100) cyc();
    chk("noleak_100", int'(Level), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
